// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: merges ex, buffered divider and queued jtag writes onto the single register-file write port
module regs_wb_arbiter #(
  parameter int JTAG_FIFO_DEPTH = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_we_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        div_valid_i,
  input  logic [4:0]  div_waddr_i,
  input  logic [31:0] div_wdata_i,
  output logic        div_ready_o,
  input  logic        jtag_we_i,
  input  logic [4:0]  jtag_addr_i,
  input  logic [31:0] jtag_data_i,
  output logic        jtag_ready_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        div_pend_o,
  output logic [4:0]  div_pend_addr_o,
  output logic        hold_req_o
);
  localparam int AW = $clog2(JTAG_FIFO_DEPTH);
  logic        div_full;
  logic [4:0]  div_addr;
  logic [31:0] div_data;
  logic [36:0] fifo [JTAG_FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [3:0]  cnt;
  logic        ex_act, div_grant, div_kill, jtag_grant, fifo_full, fifo_empty;
  logic        div_acc, jtag_push;
  logic [36:0] head;
  assign ex_act     = ex_we_i && ex_waddr_i != 5'd0;
  assign fifo_empty = wptr == rptr;
  assign fifo_full  = wptr[AW] != rptr[AW] && wptr[AW-1:0] == rptr[AW-1:0];
  assign head       = fifo[rptr[AW-1:0]];
  assign div_grant  = !ex_act && div_full;
  // a younger ex write to the same register makes the buffered result obsolete
  assign div_kill   = ex_act && div_full && ex_waddr_i == div_addr;
  assign jtag_grant = !ex_act && !div_full && !fifo_empty;
  assign div_ready_o  = !div_full || div_grant || div_kill;
  assign jtag_ready_o = !fifo_full;
  assign div_acc    = div_valid_i && div_ready_o;
  assign jtag_push  = jtag_we_i && !fifo_full && jtag_addr_i != 5'd0;
  assign we_o    = ex_act || div_grant || jtag_grant;
  assign waddr_o = ex_act ? ex_waddr_i : div_grant ? div_addr : jtag_grant ? head[36:32] : 5'd0;
  assign wdata_o = ex_act ? ex_wdata_i : div_grant ? div_data : jtag_grant ? head[31:0] : 32'd0;
  assign div_pend_o      = div_full;
  assign div_pend_addr_o = div_full ? div_addr : 5'd0;
  assign hold_req_o      = cnt >= 4'(STARVE_MAX);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_full <= 1'b0;
      div_addr <= '0;
      div_data <= '0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
    end else begin
      if (div_acc && div_waddr_i != 5'd0) begin
        div_full <= 1'b1;
        div_addr <= div_waddr_i;
        div_data <= div_wdata_i;
      end else if (div_grant || div_kill) begin
        div_full <= 1'b0;
      end
      if (jtag_push) wptr <= wptr + (AW+1)'(1);
      if (jtag_grant) rptr <= rptr + (AW+1)'(1);
      cnt <= (!(div_full || !fifo_empty) || div_grant || jtag_grant) ? 4'd0 :
             cnt == 4'hf ? cnt : cnt + 4'd1;
    end
  end
  always_ff @(posedge clk)
    if (jtag_push) fifo[wptr[AW-1:0]] <= {jtag_addr_i, jtag_data_i};
endmodule
